comparador_lote: RTL and testbench
==================================

COMPARADOR_LOTE -- requirements
Module: comparador_lote

Interface
REQ-001 Parameter ANIO_W, default 7, SHALL be the year width in bits; a year value is an offset from 2000.
REQ-002 Parameter CNT_W, default 8, SHALL be the width of each statistics counter.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 ref_load  input  1  SHALL load ref_dia/ref_mes/ref_anio into the reference date register.
REQ-006 ref_dia [4:0], ref_mes [3:0], ref_anio [ANIO_W-1:0]  input  SHALL be the reference date to load.
REQ-007 ref_avanza  input  1  SHALL advance the reference date by one calendar day.
REQ-008 in_valid  input  1 / in_ready  output  1  SHALL be the product-date handshake.
REQ-009 dia [4:0], mes [3:0], anio [ANIO_W-1:0]  input  SHALL be the product expiry date.
REQ-010 out_valid  output  1 / out_ready  input  1  SHALL be the result handshake.
REQ-011 V  output  2  SHALL be the result: 2'b01 vigente, 2'b10 vencido, 2'b11 no valido, 2'b00 no result.
REQ-012 cnt_vigente, cnt_vencido, cnt_invalido  output  CNT_W each  SHALL be result counters.

Function
REQ-013 A product date SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-015 The output register SHALL have two states, VACIO (out_valid=0) and LLENO (out_valid=1); VACIO->LLENO on accept; LLENO->VACIO on out_ready=1 with no accept; LLENO->LLENO on a simultaneous accept and out_ready=1, in which case V is replaced by the new result.
REQ-016 Latency SHALL be one cycle: V/out_valid update on the edge that accepts the date.
REQ-017 V and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 A date SHALL be no valido if mes=0, mes>12, dia=0, or dia exceeds the days in mes (31: 1,3,5,7,8,10,12; 30: 4,6,9,11; 28 for month 2 except per REQ-031).
REQ-019 A valid date SHALL be vencido if (anio,mes,dia) <= reference date, compared lexicographically; otherwise vigente.
REQ-020 Classification SHALL use the reference register value present in the accept cycle, not any value loaded or advanced on that same edge.
REQ-021 ref_load SHALL take priority over ref_avanza when both are 1.
REQ-022 ref_avanza SHALL increment the day; past month end, day becomes 1 and month increments; past month 12, month becomes 1 and year increments, wrapping modulo 2^ANIO_W.
REQ-023 ref_load with an invalid date SHALL be ignored; the reference register is unchanged.
REQ-024 Each counter SHALL increment by one when a result of its class is written to the output register, and SHALL saturate at 2^CNT_W-1.

Reset
REQ-025 On reset: out_valid=0, V=2'b00, all counters 0, reference date = 1/1/0 (1 January 2000), state VACIO.
REQ-026 Reset SHALL override any simultaneous accept, ref_load or ref_avanza; an in-flight result SHALL be discarded.
REQ-027 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-028 Macro BISIESTO_EN SHALL enable leap-year handling.
REQ-029 Without BISIESTO_EN, February SHALL have 28 days in every year for both validation and ref_avanza.
REQ-030 With BISIESTO_EN, February SHALL have 29 days when anio mod 4 = 0.
REQ-031 REQ-018 and REQ-022 SHALL use the February length from REQ-029/REQ-030.

Verification
REQ-032 Reference 22/2/21; product 22/2/21 -> V=10 next cycle, cnt_vencido=1; product 23/2/21 -> V=01.
REQ-033 Products 30/2/21, 31/6/21, 5/14/21, 0/1/21 -> V=11 for each, cnt_invalido=4.
REQ-034 Reference 31/12/127, pulse ref_avanza -> reference 1/1/0; product 1/1/0 -> V=10.
REQ-035 out_ready held 0, two products offered -> first result held stable, in_ready=0 and second not accepted; out_ready=1 -> second result follows on the next edge, in_ready=1.
REQ-036 29/2/24 -> V=11 without BISIESTO_EN, V=01 with it against reference 1/1/24; reference 28/2/24 plus ref_avanza -> 1/3/24 without it, 29/2/24 with it.
REQ-037 Reset asserted while out_valid=1 and cnt_vigente=5 -> out_valid=0, V=00, counters 0, reference 1/1/0 next cycle.

Source files
------------

// File: rtl/comparador_lote.sv
// Batch expiry-date classifier: compares product dates against a reference date register.
// Optional leap-year February handling is enabled by defining BISIESTO_EN.
module comparador_lote #(
  parameter int ANIO_W = 7,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ref_load,
  input  logic [4:0]        ref_dia,
  input  logic [3:0]        ref_mes,
  input  logic [ANIO_W-1:0] ref_anio,
  input  logic              ref_avanza,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        dia,
  input  logic [3:0]        mes,
  input  logic [ANIO_W-1:0] anio,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        V,
  output logic [CNT_W-1:0]  cnt_vigente,
  output logic [CNT_W-1:0]  cnt_vencido,
  output logic [CNT_W-1:0]  cnt_invalido,
  output logic              state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready depends only on the output register state and out_ready, never on in_valid.

  typedef enum logic {VACIO = 1'b0, LLENO = 1'b1} estado_t;

  localparam logic [1:0] V_NADA     = 2'b00;
  localparam logic [1:0] V_VIGENTE  = 2'b01;
  localparam logic [1:0] V_VENCIDO  = 2'b10;
  localparam logic [1:0] V_INVALIDO = 2'b11;

  estado_t           state_q, state_d;
  logic [1:0]        v_q, v_d;
  logic [4:0]        ref_dia_q, ref_dia_d;
  logic [3:0]        ref_mes_q, ref_mes_d;
  logic [ANIO_W-1:0] ref_anio_q, ref_anio_d;
  logic [CNT_W-1:0]  cnt_vig_q, cnt_vig_d;
  logic [CNT_W-1:0]  cnt_ven_q, cnt_ven_d;
  logic [CNT_W-1:0]  cnt_inv_q, cnt_inv_d;

  logic       accept;
  logic       bis_prod, bis_ref, bis_load;
  logic       prod_ok, load_ok, prod_vencido;
  logic [1:0] res;

  // Returns 0 for months outside 1..12 so any day fails the range check.
  function automatic logic [4:0] dias_mes(input logic [3:0] m, input logic bis);
    logic [4:0] n;
    n = 5'd0;
    case (m)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: n = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                    n = 5'd30;
      4'd2:                                       n = bis ? 5'd29 : 5'd28;
      default:                                    n = 5'd0;
    endcase
    return n;
  endfunction

  function automatic logic fecha_ok(input logic [4:0] d, input logic [3:0] m, input logic bis);
    return (d != 5'd0) && (d <= dias_mes(m, bis));
  endfunction

`ifdef BISIESTO_EN
  assign bis_prod = (anio[1:0] == 2'b00);
  assign bis_ref  = (ref_anio_q[1:0] == 2'b00);
  assign bis_load = (ref_anio[1:0] == 2'b00);
`else
  assign bis_prod = 1'b0;
  assign bis_ref  = 1'b0;
  assign bis_load = 1'b0;
`endif

  assign accept       = in_valid && in_ready;
  assign prod_ok      = fecha_ok(dia, mes, bis_prod);
  assign load_ok      = fecha_ok(ref_dia, ref_mes, bis_load);
  assign prod_vencido = {anio, mes, dia} <= {ref_anio_q, ref_mes_q, ref_dia_q};
  assign res          = !prod_ok ? V_INVALIDO : (prod_vencido ? V_VENCIDO : V_VIGENTE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= VACIO;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      VACIO:   if (accept) state_d = LLENO;
      LLENO:   if (out_ready && !accept) state_d = VACIO;
      default: state_d = VACIO;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid   = (state_q == LLENO);
    in_ready    = (state_q == VACIO) || out_ready;
    state_dbg_o = state_q;
  end

  // Result and counters; V returns to "no result" once the result is taken.
  always_comb begin
    v_d       = v_q;
    cnt_vig_d = cnt_vig_q;
    cnt_ven_d = cnt_ven_q;
    cnt_inv_d = cnt_inv_q;
    if (accept) begin
      v_d = res;
      case (res)
        V_VIGENTE: if (cnt_vig_q != {CNT_W{1'b1}}) cnt_vig_d = cnt_vig_q + CNT_W'(1);
        V_VENCIDO: if (cnt_ven_q != {CNT_W{1'b1}}) cnt_ven_d = cnt_ven_q + CNT_W'(1);
        default:   if (cnt_inv_q != {CNT_W{1'b1}}) cnt_inv_d = cnt_inv_q + CNT_W'(1);
      endcase
    end else if (out_valid && out_ready) begin
      v_d = V_NADA;
    end
  end

  // Reference date: any ref_load cycle blocks ref_avanza, even if the loaded date is rejected.
  always_comb begin
    ref_dia_d  = ref_dia_q;
    ref_mes_d  = ref_mes_q;
    ref_anio_d = ref_anio_q;
    if (ref_load) begin
      if (load_ok) begin
        ref_dia_d  = ref_dia;
        ref_mes_d  = ref_mes;
        ref_anio_d = ref_anio;
      end
    end else if (ref_avanza) begin
      if (ref_dia_q >= dias_mes(ref_mes_q, bis_ref)) begin
        ref_dia_d = 5'd1;
        if (ref_mes_q >= 4'd12) begin
          ref_mes_d  = 4'd1;
          ref_anio_d = ref_anio_q + {{(ANIO_W-1){1'b0}}, 1'b1};
        end else begin
          ref_mes_d = ref_mes_q + 4'd1;
        end
      end else begin
        ref_dia_d = ref_dia_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q        <= V_NADA;
      cnt_vig_q  <= '0;
      cnt_ven_q  <= '0;
      cnt_inv_q  <= '0;
      ref_dia_q  <= 5'd1;
      ref_mes_q  <= 4'd1;
      ref_anio_q <= '0;
    end else begin
      v_q        <= v_d;
      cnt_vig_q  <= cnt_vig_d;
      cnt_ven_q  <= cnt_ven_d;
      cnt_inv_q  <= cnt_inv_d;
      ref_dia_q  <= ref_dia_d;
      ref_mes_q  <= ref_mes_d;
      ref_anio_q <= ref_anio_d;
    end
  end

  assign V            = v_q;
  assign cnt_vigente  = cnt_vig_q;
  assign cnt_vencido  = cnt_ven_q;
  assign cnt_invalido = cnt_inv_q;

endmodule

// File: tb/tb_comparador_lote.sv
// Bench for comparador_lote: reference-model scoreboard over directed and random product dates.
// Expectations follow BISIESTO_EN when it is defined for the build.
module tb_comparador_lote;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ref_load = 1'b0, ref_avanza = 1'b0;
  logic [4:0] ref_dia = 5'd1;
  logic [3:0] ref_mes = 4'd1;
  logic [6:0] ref_anio = 7'd0;
  logic       in_valid = 1'b0, in_ready;
  logic [4:0] dia = 5'd1;
  logic [3:0] mes = 4'd1;
  logic [6:0] anio = 7'd0;
  logic       out_valid, out_ready = 1'b1;
  logic [1:0] V;
  logic [7:0] cnt_vigente, cnt_vencido, cnt_invalido;
  logic       state_dbg_o;

  comparador_lote #(.ANIO_W(7), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .ref_load(ref_load), .ref_dia(ref_dia), .ref_mes(ref_mes), .ref_anio(ref_anio),
    .ref_avanza(ref_avanza),
    .in_valid(in_valid), .in_ready(in_ready),
    .dia(dia), .mes(mes), .anio(anio),
    .out_valid(out_valid), .out_ready(out_ready), .V(V),
    .cnt_vigente(cnt_vigente), .cnt_vencido(cnt_vencido), .cnt_invalido(cnt_invalido),
    .state_dbg_o(state_dbg_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  int m_d = 1, m_m = 1, m_a = 0;
  int m_cv = 0, m_cx = 0, m_ci = 0;
  bit rand_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_dias(input int m, input int a);
    int n;
    n = 0;
    if (m == 1 || m == 3 || m == 5 || m == 7 || m == 8 || m == 10 || m == 12) n = 31;
    else if (m == 4 || m == 6 || m == 9 || m == 11) n = 30;
    else if (m == 2) begin
      n = 28;
`ifdef BISIESTO_EN
      if (a % 4 == 0) n = 29;
`endif
    end
    return n;
  endfunction

  function automatic logic [1:0] model_v(input int d, input int m, input int a);
    int k, kr;
    if (m < 1 || m > 12 || d < 1 || d > m_dias(m, a)) return 2'b11;
    k  = (a * 16 + m) * 32 + d;
    kr = (m_a * 16 + m_m) * 32 + m_d;
    return (k <= kr) ? 2'b10 : 2'b01;
  endfunction

  function automatic void model_count(input logic [1:0] e);
    if (e == 2'b01 && m_cv < 255) m_cv++;
    if (e == 2'b10 && m_cx < 255) m_cx++;
    if (e == 2'b11 && m_ci < 255) m_ci++;
  endfunction

  function automatic void model_reset();
    m_d = 1; m_m = 1; m_a = 0;
    m_cv = 0; m_cx = 0; m_ci = 0;
    exp_q.delete();
  endfunction

  // ---------------- driver tasks (called at posedge + #1) ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_ref(input int d, input int m, input int a);
    ref_dia = 5'(d); ref_mes = 4'(m); ref_anio = 7'(a);
    ref_load = 1'b1;
    tick(1);
    ref_load = 1'b0;
    if (m >= 1 && m <= 12 && d >= 1 && d <= m_dias(m, a)) begin
      m_d = d; m_m = m; m_a = a;
    end
  endtask

  task automatic avanza();
    ref_avanza = 1'b1;
    tick(1);
    ref_avanza = 1'b0;
    if (m_d >= m_dias(m_m, m_a)) begin
      m_d = 1;
      if (m_m == 12) begin m_m = 1; m_a = (m_a + 1) % 128; end
      else m_m++;
    end else m_d++;
  endtask

  task automatic send(input int d, input int m, input int a);
    logic [1:0] e;
    bit ok;
    ok = 1'b0;
    dia = 5'(d); mes = 4'(m); anio = 7'(a);
    in_valid = 1'b1;
    e = model_v(d, m, a);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        exp_q.push_back(e);
        model_count(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("accept_timeout", 32'(ok), 32'd1);
    if (ok) begin
      check("lat_out_valid", 32'(out_valid), 32'd1);
      check("lat_v", 32'(V), 32'(e));
      check("cnt_vigente", 32'(cnt_vigente), 32'(m_cv));
      check("cnt_vencido", 32'(cnt_vencido), 32'(m_cx));
      check("cnt_invalido", 32'(cnt_invalido), 32'(m_ci));
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    tick(1);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
      else check("sb_v", 32'(V), 32'(exp_q.pop_front()));
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] e_a, e_b;
    tick(3);
    reset = 1'b0;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_v", 32'(V), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(state_dbg_o), 32'd0);

    // Reference 22/2/21: equal date expires, next day does not.
    set_ref(22, 2, 21);
    send(22, 2, 21);
    send(23, 2, 21);
    drain();

    // Invalid dates.
    send(30, 2, 21); send(31, 6, 21); send(5, 14, 21); send(0, 1, 21);
    drain();
    check("cnt_invalido_4", 32'(cnt_invalido), 32'd4);

    // Year wrap on ref_avanza.
    set_ref(31, 12, 127);
    avanza();
    send(1, 1, 0);
    send(2, 1, 0);
    // Invalid ref_load is ignored; ref_load wins over ref_avanza.
    set_ref(31, 4, 50);
    send(1, 1, 0);
    ref_avanza = 1'b1;
    set_ref(10, 1, 0);
    ref_avanza = 1'b0;
    send(10, 1, 0);
    send(11, 1, 0);
    drain();

    // February 2024 with and without leap handling.
    set_ref(1, 1, 24);
    send(29, 2, 24);
    set_ref(28, 2, 24);
    avanza();
    send(29, 2, 24);
    send(1, 3, 24);
    send(2, 3, 24);
    drain();

    // Back-pressure: first result held, second waits.
    out_ready = 1'b0;
    send(5, 5, 30);
    e_a = model_v(5, 5, 30);
    dia = 5'd10; mes = 4'd1; anio = 7'd10; in_valid = 1'b1;
    e_b = model_v(10, 1, 10);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_v", 32'(V), 32'(e_a));
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(e_b);
    model_count(e_b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("release_v", 32'(V), 32'(e_b));
    check("release_out_valid", 32'(out_valid), 32'd1);
    check("release_in_ready2", 32'(in_ready), 32'd1);
    drain();

    // Reset with a held result and cnt_vigente = 5, plus colliding ref controls.
    do_reset();
    for (int i = 0; i < 4; i++) send(2 + i, 1, 0);
    tick(1);
    out_ready = 1'b0;
    send(20, 1, 0);
    check("pre_rst_cnt_vig", 32'(cnt_vigente), 32'd5);
    ref_dia = 5'd5; ref_mes = 4'd5; ref_anio = 7'd5;
    ref_load = 1'b1; ref_avanza = 1'b1; in_valid = 1'b1;
    do_reset();
    ref_load = 1'b0; ref_avanza = 1'b0; in_valid = 1'b0;
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_v", 32'(V), 32'd0);
    check("rst2_cnt_vig", 32'(cnt_vigente), 32'd0);
    check("rst2_cnt_ven", 32'(cnt_vencido), 32'd0);
    check("rst2_cnt_inv", 32'(cnt_invalido), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send(1, 1, 0);
    send(2, 1, 0);
    drain();

    // Random dates with random back-pressure.
    set_ref(15, 6, 60);
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send($urandom_range(0, 31), $urandom_range(0, 13), $urandom_range(55, 65));
      if ($urandom_range(0, 9) == 0) avanza();
    end
    // Push the invalid counter into saturation.
    for (int i = 0; i < 260; i++) send($urandom_range(1, 31), 0, $urandom_range(0, 127));
    rand_rdy = 1'b0;
    tick(1);
    drain();
    check("sat_cnt_invalido", 32'(cnt_invalido), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
